vga_timing_gen: RTL

//  Parametrised VGA raster timing generator; next generation of the fixed 640x480 H/V counter pair.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 74 +++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA timing generator.
// The defaults describe 640x480@60. The helper derives the line and frame totals.
package vga_timing_pkg;

   localparam int unsigned DEF_CNT_W    = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;

   function automatic int unsigned axis_total(input int unsigned sync,
                                              input int unsigned bp,
                                              input int unsigned active,
                                              input int unsigned fp);
      return sync + bp + active + fp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter and its registered sync level.
// The next-state active flag and coordinate are exported so the top can register de and pix_x/pix_y.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned TOTAL  = 800,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BP     = 48,
   parameter int unsigned ACTIVE = 640,
   parameter bit          POL    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_end,
   output logic             sync,
   output logic             active_nxt,
   output logic [CNT_W-1:0] coord_nxt
);

   // A total of exactly TOTAL > SYNC+BP+ACTIVE guarantees a non-empty front porch.
   if (SYNC == 0 || BP == 0 || ACTIVE == 0 || TOTAL <= SYNC + BP + ACTIVE ||
       longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_params
      $error("vga_axis_counter: illegal timing parameters");
   end

   localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
   localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BP);
   localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BP + ACTIVE);

   logic [CNT_W-1:0] cnt_nxt;

   assign at_end = (count == LAST);

   always_comb begin
      cnt_nxt = count;
      if (rst)
         cnt_nxt = '0;
      else if (inc)
         cnt_nxt = at_end ? '0 : count + 1'b1;
   end

   assign active_nxt = (cnt_nxt >= ACT_LO) && (cnt_nxt < ACT_HI);
   assign coord_nxt  = active_nxt ? cnt_nxt - ACT_LO : '0;

   always_ff @(posedge clk) begin
      if (rst || inc) begin
         count <= cnt_nxt;
         sync  <= (cnt_nxt < SYNC_END) ? POL : ~POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator with a pixel-clock enable.
// The decoded outputs are registered from next-state counters, so they line up with h_count/v_count.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_en,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] h_count,
   output logic [CNT_W-1:0] v_count,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic             line_end,
   output logic             frame_end
);

   localparam int unsigned H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int unsigned V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

   if (H_FP == 0 || V_FP == 0) begin : g_bad_porch
      $error("vga_timing_gen: front porch must be non-zero");
   end

   logic             h_end, v_end;
   logic             h_act_n, v_act_n;
   logic [CNT_W-1:0] h_coord_n, v_coord_n;

   // The vertical axis steps only on the last pixel of a line, never while in reset.
   assign line_end  = pix_en & h_end & ~rst;
   assign frame_end = line_end & v_end;

   vga_axis_counter #(
      .CNT_W (CNT_W), .TOTAL(H_TOTAL), .SYNC(H_SYNC), .BP(H_BP),
      .ACTIVE(H_ACTIVE), .POL(HS_POL)
   ) u_h (
      .clk(clk), .rst(rst), .inc(pix_en), .count(h_count), .at_end(h_end),
      .sync(hsync), .active_nxt(h_act_n), .coord_nxt(h_coord_n)
   );

   vga_axis_counter #(
      .CNT_W (CNT_W), .TOTAL(V_TOTAL), .SYNC(V_SYNC), .BP(V_BP),
      .ACTIVE(V_ACTIVE), .POL(VS_POL)
   ) u_v (
      .clk(clk), .rst(rst), .inc(line_end), .count(v_count), .at_end(v_end),
      .sync(vsync), .active_nxt(v_act_n), .coord_nxt(v_coord_n)
   );

   logic de_n;
   assign de_n = h_act_n & v_act_n;

   always_ff @(posedge clk) begin
      if (rst || pix_en) begin
         de    <= de_n;
         pix_x <= de_n ? h_coord_n : '0;
         pix_y <= de_n ? v_coord_n : '0;
      end
   end

endmodule
